// File: rtl/wb_sram_bank_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : wb_sram_bank_ctrl                                             |
// | Purpose  : Wishbone slave mapping an address window onto NUM_BANKS       |
// |            sky130 1rw1r SRAM macros. Port 0 serves Wishbone read/write   |
// |            with byte masks; port 1 serves an optional pipelined          |
// |            read-only client.                                             |
// | Options  : SRAM_PORT1_EN - when defined, the port-1 read client is built;|
// |            otherwise port-1 outputs are tied off and no flops exist.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module wb_sram_bank_ctrl #(
  parameter int unsigned NUM_BANKS = 2,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DATA_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          wbs_cyc_i,
  input  logic                          wbs_stb_i,
  input  logic                          wbs_we_i,
  input  logic [3:0]                    wbs_sel_i,
  input  logic [31:0]                   wbs_adr_i,
  input  logic [31:0]                   wbs_dat_i,
  output logic                          wbs_ack_o,
  output logic [31:0]                   wbs_dat_o,
  output logic [NUM_BANKS-1:0]          sram_csb0_o,
  output logic [NUM_BANKS-1:0]          sram_web0_o,
  output logic [4*NUM_BANKS-1:0]        sram_wmask0_o,
  output logic [ADDR_W*NUM_BANKS-1:0]   sram_addr0_o,
  output logic [DATA_W*NUM_BANKS-1:0]   sram_din0_o,
  input  logic [DATA_W*NUM_BANKS-1:0]   sram_dout0_i,
  output logic [NUM_BANKS-1:0]          sram_csb1_o,
  output logic [ADDR_W*NUM_BANKS-1:0]   sram_addr1_o,
  input  logic [DATA_W*NUM_BANKS-1:0]   sram_dout1_i,
  input  logic                          rd_req_i,
  input  logic [ADDR_W+2:0]             rd_addr_i,
  output logic                          rd_ready_o,
  output logic                          rd_valid_o,
  output logic [31:0]                   rd_data_o
);

  // Elaboration-time parameter sanity checks
  if (DATA_W != 32) begin : g_chk_data_w
    $error("wb_sram_bank_ctrl: DATA_W must be 32");
  end
  if (NUM_BANKS < 1 || NUM_BANKS > 8) begin : g_chk_num_banks
    $error("wb_sram_bank_ctrl: NUM_BANKS must be in 1..8");
  end

  // Window bounds computed in 34 bits so the top of the window cannot wrap
  localparam logic [33:0] c_WIN_LO    = {2'b00, BASE_ADDR};
  localparam logic [33:0] c_WIN_HI    = c_WIN_LO + (34'(NUM_BANKS) << (ADDR_W + 2));
  localparam logic [3:0]  c_NUM_BANKS = 4'(NUM_BANKS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                we_q;
  logic [3:0]          sel_q;
  logic [ADDR_W-1:0]   row_q;
  logic [2:0]          bank_q;
  logic [31:0]         data_q;
  logic                hit_q;    // captured address maps to a real bank
  logic                abort_q;  // master dropped cyc; finish access silently
  logic [31:0]         dat_q;

  logic [33:0]         w_adr_ext;
  logic [2:0]          w_wb_bank;
  logic [ADDR_W-1:0]   w_wb_row;
  logic                w_wb_hit;
  logic [31:0]         w_rdata0;

  assign w_adr_ext = {2'b00, wbs_adr_i};
  assign w_wb_row  = wbs_adr_i[ADDR_W+1:2];
  assign w_wb_bank = wbs_adr_i[ADDR_W+4:ADDR_W+2];
  assign w_wb_hit  = (w_adr_ext >= c_WIN_LO) && (w_adr_ext < c_WIN_HI) &&
                     ({1'b0, w_wb_bank} < c_NUM_BANKS);
  assign wbs_dat_o = dat_q;

  // Select the port-0 read word of the captured bank
  always_comb begin
    w_rdata0 = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_q == b[2:0]) w_rdata0 = sram_dout0_i[b*DATA_W +: DATA_W];
    end
  end

  // Port-0 state register, request capture and read-data capture
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      sel_q   <= '0;
      row_q   <= '0;
      bank_q  <= '0;
      data_q  <= '0;
      hit_q   <= 1'b0;
      abort_q <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && wbs_cyc_i && wbs_stb_i) begin
        we_q    <= wbs_we_i;
        sel_q   <= wbs_sel_i;
        row_q   <= w_wb_row;
        bank_q  <= w_wb_bank;
        data_q  <= wbs_dat_i;
        hit_q   <= w_wb_hit;
        abort_q <= 1'b0;
      end
      if ((state_q == ST_ACCESS || state_q == ST_WAIT) && !wbs_cyc_i) begin
        abort_q <= 1'b1;
      end
      if (state_q == ST_WAIT) begin
        dat_q <= hit_q ? w_rdata0 : '0;
      end
    end
  end

  // Port-0 next state and macro/ack outputs; strobe only during ACCESS
  always_comb begin
    state_d       = state_q;
    sram_csb0_o   = '1;
    sram_web0_o   = '1;
    sram_wmask0_o = '0;
    sram_addr0_o  = '0;
    sram_din0_o   = '0;
    wbs_ack_o     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        for (int b = 0; b < NUM_BANKS; b++) begin
          if (hit_q && bank_q == b[2:0]) begin
            sram_csb0_o[b]                  = 1'b0;
            sram_web0_o[b]                  = ~we_q;
            sram_addr0_o[b*ADDR_W +: ADDR_W] = row_q;
            if (we_q) begin
              sram_wmask0_o[b*4 +: 4]         = sel_q;
              sram_din0_o[b*DATA_W +: DATA_W] = data_q;
            end
          end
        end
        state_d = we_q ? ST_ACK : ST_WAIT;
      end
      ST_WAIT: begin
        state_d = ST_ACK;
      end
      ST_ACK: begin
        wbs_ack_o = ~abort_q;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef SRAM_PORT1_EN
  logic              p1_vld_q, p1_ok_q;
  logic [2:0]        p1_bank_q;
  logic [ADDR_W-1:0] p1_row_q;
  logic              rv_vld_q, rv_ok_q;
  logic [2:0]        rv_bank_q;
  logic [2:0]        w_rd_bank;
  logic [ADDR_W-1:0] w_rd_row;

  assign w_rd_bank  = rd_addr_i[ADDR_W+2:ADDR_W];
  assign w_rd_row   = rd_addr_i[ADDR_W-1:0];
  // Hold off a read that would hit the row port 0 is writing this cycle
  assign rd_ready_o = ~(state_q == ST_ACCESS && we_q && hit_q &&
                        bank_q == w_rd_bank && row_q == w_rd_row);
  assign rd_valid_o = rv_vld_q;

  // Two-stage port-1 pipeline: strobe stage then data-return stage
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      p1_vld_q  <= 1'b0;
      p1_ok_q   <= 1'b0;
      p1_bank_q <= '0;
      p1_row_q  <= '0;
      rv_vld_q  <= 1'b0;
      rv_ok_q   <= 1'b0;
      rv_bank_q <= '0;
    end else begin
      p1_vld_q <= rd_req_i && rd_ready_o;
      if (rd_req_i && rd_ready_o) begin
        p1_bank_q <= w_rd_bank;
        p1_row_q  <= w_rd_row;
        p1_ok_q   <= ({1'b0, w_rd_bank} < c_NUM_BANKS);
      end
      rv_vld_q  <= p1_vld_q;
      rv_ok_q   <= p1_ok_q;
      rv_bank_q <= p1_bank_q;
    end
  end

  // Port-1 macro strobes and returned-data mux
  always_comb begin
    sram_csb1_o  = '1;
    sram_addr1_o = '0;
    rd_data_o    = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (p1_vld_q && p1_ok_q && p1_bank_q == b[2:0]) begin
        sram_csb1_o[b]                   = 1'b0;
        sram_addr1_o[b*ADDR_W +: ADDR_W] = p1_row_q;
      end
      if (rv_vld_q && rv_ok_q && rv_bank_q == b[2:0]) begin
        rd_data_o = sram_dout1_i[b*DATA_W +: DATA_W];
      end
    end
  end
`else
  logic unused_p1;

  assign sram_csb1_o  = '1;
  assign sram_addr1_o = '0;
  assign rd_ready_o   = 1'b0;
  assign rd_valid_o   = 1'b0;
  assign rd_data_o    = '0;
  assign unused_p1    = ^{rd_req_i, rd_addr_i, sram_dout1_i};
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_sram_bank_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_wb_sram_bank_ctrl                                          |
// | Purpose  : Self-checking bench for wb_sram_bank_ctrl with a behavioural  |
// |            1rw1r SRAM model per bank. Port-1 scenarios run when          |
// |            SRAM_PORT1_EN is defined, tie-offs are checked otherwise.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_wb_sram_bank_ctrl;
  localparam int NB = 2;
  localparam int AW = 9;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wbs_cyc = 1'b0, wbs_stb = 1'b0, wbs_we = 1'b0;
  logic [3:0]        wbs_sel = '0;
  logic [31:0]       wbs_adr = '0, wbs_dat = '0;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic [NB-1:0]     csb0, web0, csb1;
  logic [4*NB-1:0]   wmask0;
  logic [AW*NB-1:0]  addr0, addr1;
  logic [32*NB-1:0]  din0, dout0, dout1;
  logic              rd_req = 1'b0;
  logic [AW+2:0]     rd_addr = '0;
  logic              rd_ready_o, rd_valid_o;
  logic [31:0]       rd_data_o;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] wb_exp_q[$];
  logic [31:0] p1_exp_q[$];

  wb_sram_bank_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(wbs_cyc), .wbs_stb_i(wbs_stb), .wbs_we_i(wbs_we),
    .wbs_sel_i(wbs_sel), .wbs_adr_i(wbs_adr), .wbs_dat_i(wbs_dat),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .sram_csb0_o(csb0), .sram_web0_o(web0), .sram_wmask0_o(wmask0),
    .sram_addr0_o(addr0), .sram_din0_o(din0), .sram_dout0_i(dout0),
    .sram_csb1_o(csb1), .sram_addr1_o(addr1), .sram_dout1_i(dout1),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ready_o(rd_ready_o),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o)
  );

  always #5 clk = ~clk;

  // Behavioural 1rw1r macros: reads return pre-write contents on the edge
  logic [31:0] mem [NB][512];
  int unsigned csb0_cnt [NB];
  logic [AW-1:0] last_addr0 [NB];
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (!csb1[b]) dout1[b*32 +: 32] <= mem[b][addr1[b*AW +: AW]];
      if (!csb0[b]) begin
        csb0_cnt[b]   = csb0_cnt[b] + 1;
        last_addr0[b] = addr0[b*AW +: AW];
        if (web0[b]) dout0[b*32 +: 32] <= mem[b][addr0[b*AW +: AW]];
        else begin
          for (int k = 0; k < 4; k++)
            if (wmask0[b*4+k]) mem[b][addr0[b*AW +: AW]][k*8 +: 8] = din0[b*32+k*8 +: 8];
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // One Wishbone transaction; lat = cycles from sampling edge to ack (-1 on timeout)
  task automatic wb_txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] wdat, output logic [31:0] rdat, output int lat);
    @(negedge clk);
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = we;
    wbs_adr = adr;  wbs_sel = sel;  wbs_dat = wdat;
    lat = -1; rdat = '0;
    for (int i = 1; i <= 10 && lat < 0; i++) begin
      @(negedge clk);
      if (wbs_ack_o) begin lat = i; rdat = wbs_dat_o; end
    end
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    n_total++;
    if (lat < 0) $display("FAIL wb_timeout adr=%h: no ack within 10 cycles", adr);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({wbs_ack_o, wbs_dat_o} !== 33'h0)
      $display("FAIL reset_wb: ack=%b dat=%h, required 0/0", wbs_ack_o, wbs_dat_o);
    else n_pass++;
    n_total++;
    if ({csb0, web0, csb1} !== {3*NB{1'b1}})
      $display("FAIL reset_csb_web: csb0=%b web0=%b csb1=%b, required all ones", csb0, web0, csb1);
    else n_pass++;
    n_total++;
    if ({wmask0, addr0, din0} !== '0)
      $display("FAIL reset_port0_bus: wmask=%h addr=%h din=%h, required 0", wmask0, addr0, din0);
    else n_pass++;
    n_total++;
    if ({rd_valid_o, rd_data_o} !== 33'h0)
      $display("FAIL reset_port1: valid=%b data=%h, required 0/0", rd_valid_o, rd_data_o);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_write_basic();
    logic [31:0] rd; int lat; int unsigned c0, c1;
    c0 = csb0_cnt[0]; c1 = csb0_cnt[1];
    wb_txn(1'b1, 32'h3000_0804, 4'hF, 32'hDEAD_BEEF, rd, lat);
    n_total++;
    if (lat !== 2) $display("FAIL write_latency: got %0d, required 2", lat);
    else n_pass++;
    n_total++;
    if (csb0_cnt[1] - c1 !== 1 || csb0_cnt[0] - c0 !== 0)
      $display("FAIL write_csb_cycles: bank1=%0d bank0=%0d, required 1/0",
               csb0_cnt[1] - c1, csb0_cnt[0] - c0);
    else n_pass++;
    n_total++;
    if (last_addr0[1] !== 9'd1) $display("FAIL write_addr0: got %0d, required 1", last_addr0[1]);
    else n_pass++;
  endtask

  task automatic test_byte_mask();
    logic [31:0] rd, exp; int lat;
    wb_txn(1'b1, 32'h3000_0008, 4'hF, 32'h1122_3344, rd, lat);
    wb_txn(1'b1, 32'h3000_0008, 4'b0101, 32'hAABB_CCDD, rd, lat);
    wb_exp_q.push_back(32'h11BB_33DD);
    wb_txn(1'b0, 32'h3000_0008, 4'hF, 32'h0, rd, lat);
    exp = wb_exp_q.pop_front();
    n_total++;
    if (rd !== exp) $display("FAIL mask_read_data: got %h, required %h", rd, exp);
    else n_pass++;
    n_total++;
    if (lat !== 3) $display("FAIL read_latency: got %0d, required 3", lat);
    else n_pass++;
  endtask

  task automatic test_window_edges();
    logic [31:0] rd, exp; int lat; int unsigned c0, c1;
    logic [31:0] adrs [3];
    adrs[0] = 32'h3000_1000; adrs[1] = 32'h2FFF_FFFC; adrs[2] = 32'hFFFF_FFFC;
    for (int i = 0; i < 3; i++) begin
      c0 = csb0_cnt[0]; c1 = csb0_cnt[1];
      wb_txn(1'b1, adrs[i], 4'hF, 32'h5555_5555, rd, lat);
      wb_exp_q.push_back(32'h0);
      wb_txn(1'b0, adrs[i], 4'hF, 32'h0, rd, lat);
      exp = wb_exp_q.pop_front();
      n_total++;
      if (rd !== exp || lat !== 3)
        $display("FAIL oow_read %h: data=%h lat=%0d, required %h/3", adrs[i], rd, lat, exp);
      else n_pass++;
      n_total++;
      if (csb0_cnt[0] != c0 || csb0_cnt[1] != c1)
        $display("FAIL oow_csb %h: strobes=%0d, required 0", adrs[i],
                 (csb0_cnt[0] - c0) + (csb0_cnt[1] - c1));
      else n_pass++;
    end
    // Last word of the window is still a valid location
    wb_txn(1'b1, 32'h3000_0FFC, 4'hF, 32'h0F0F_F0F0, rd, lat);
    wb_exp_q.push_back(32'h0F0F_F0F0);
    wb_txn(1'b0, 32'h3000_0FFC, 4'hF, 32'h0, rd, lat);
    exp = wb_exp_q.pop_front();
    n_total++;
    if (rd !== exp || last_addr0[1] !== 9'd511)
      $display("FAIL top_of_window: data=%h row=%0d, required %h/511", rd, last_addr0[1], exp);
    else n_pass++;
  endtask

  task automatic test_cyc_abort();
    logic [31:0] rd, exp; int lat, acks; int unsigned c0;
    c0 = csb0_cnt[0]; acks = 0;
    @(negedge clk);
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b1;
    wbs_adr = 32'h3000_0024; wbs_sel = 4'hF; wbs_dat = 32'h1234_5678;
    @(negedge clk);
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (wbs_ack_o) acks++;
      @(negedge clk);
    end
    n_total++;
    if (acks != 0 || csb0_cnt[0] - c0 != 1)
      $display("FAIL cyc_abort: acks=%0d strobes=%0d, required 0/1", acks, csb0_cnt[0] - c0);
    else n_pass++;
    wb_exp_q.push_back(32'h1234_5678);
    wb_txn(1'b0, 32'h3000_0024, 4'hF, 32'h0, rd, lat);
    exp = wb_exp_q.pop_front();
    n_total++;
    if (rd !== exp) $display("FAIL cyc_abort_readback: got %h, required %h", rd, exp);
    else n_pass++;
  endtask

`ifdef SRAM_PORT1_EN
  task automatic test_port1_burst();
    logic [31:0] rd, exp; int lat, first_v, last_v, n_v, bad;
    for (int r = 0; r < 8; r++)
      wb_txn(1'b1, 32'h3000_0000 + 32'(r * 4), 4'hF, 32'hA500_0000 + 32'(r), rd, lat);
    first_v = -1; last_v = -1; n_v = 0; bad = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (rd_valid_o) begin
        if (first_v < 0) first_v = t;
        last_v = t; n_v++;
        if (p1_exp_q.size() == 0) exp = 32'hXXXX_XXXX;
        else exp = p1_exp_q.pop_front();
        n_total++;
        if (rd_data_o !== exp) $display("FAIL p1_burst_data t=%0d: got %h, required %h", t, rd_data_o, exp);
        else n_pass++;
      end
      if (t < 8) begin
        rd_req = 1'b1; rd_addr = {3'd0, 9'(t)};
        #1;
        if (rd_ready_o) p1_exp_q.push_back(32'hA500_0000 + 32'(t));
        else bad++;
      end else rd_req = 1'b0;
    end
    n_total++;
    if (first_v != 2 || n_v != 8 || last_v - first_v != 7 || bad != 0 || p1_exp_q.size() != 0)
      $display("FAIL p1_burst_timing: first=%0d count=%0d span=%0d stalls=%0d, required 2/8/7/0",
               first_v, n_v, last_v - first_v, bad);
    else n_pass++;
  endtask
`else
  task automatic test_port1_burst();
    int bad_rdy, bad_out;
    bad_rdy = 0; bad_out = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      rd_req = (t < 4); rd_addr = {3'd0, 9'(t)};
      #1;
      if (rd_ready_o !== 1'b0) bad_rdy++;
      if (rd_valid_o !== 1'b0 || rd_data_o !== 32'h0 || csb1 !== {NB{1'b1}} || addr1 !== '0) bad_out++;
    end
    rd_req = 1'b0;
    n_total++;
    if (bad_rdy != 0) $display("FAIL p1_off_ready: %0d cycles with ready, required 0", bad_rdy);
    else n_pass++;
    n_total++;
    if (bad_out != 0) $display("FAIL p1_off_outputs: %0d active cycles, required 0", bad_out);
    else n_pass++;
  endtask
`endif

  task automatic test_collision();
    logic [31:0] rd, exp; int lat;
    @(negedge clk);
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b1;
    wbs_adr = 32'h3000_0014; wbs_sel = 4'hF; wbs_dat = 32'hC0FF_EE05;
    rd_addr = {3'd0, 9'd5}; rd_req = 1'b0;
    #1;
`ifdef SRAM_PORT1_EN
    n_total++;
    if (rd_ready_o !== 1'b1) $display("FAIL coll_ready_idle: got %b, required 1", rd_ready_o);
    else n_pass++;
`endif
    @(negedge clk);
`ifdef SRAM_PORT1_EN
    n_total++;
    if (rd_ready_o !== 1'b0) $display("FAIL coll_ready_access: got %b, required 0", rd_ready_o);
    else n_pass++;
    rd_req = 1'b1;
`endif
    @(negedge clk);
    n_total++;
    if (wbs_ack_o !== 1'b1) $display("FAIL coll_write_ack: got %b, required 1", wbs_ack_o);
    else n_pass++;
`ifdef SRAM_PORT1_EN
    n_total++;
    if (rd_ready_o !== 1'b1) $display("FAIL coll_ready_ack: got %b, required 1", rd_ready_o);
    else n_pass++;
    if (rd_req && rd_ready_o) p1_exp_q.push_back(32'hC0FF_EE05);
`endif
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    @(negedge clk);
    rd_req = 1'b0;
`ifdef SRAM_PORT1_EN
    @(negedge clk);
    if (p1_exp_q.size() == 0) exp = 32'hXXXX_XXXX;
    else exp = p1_exp_q.pop_front();
    n_total++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== exp)
      $display("FAIL coll_p1_return: valid=%b data=%h, required 1/%h", rd_valid_o, rd_data_o, exp);
    else n_pass++;
`endif
    wb_exp_q.push_back(32'hC0FF_EE05);
    wb_txn(1'b0, 32'h3000_0014, 4'hF, 32'h0, rd, lat);
    exp = wb_exp_q.pop_front();
    n_total++;
    if (rd !== exp) $display("FAIL coll_readback: got %h, required %h", rd, exp);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, exp; int lat, acks;
    for (int s = 1; s <= 2; s++) begin
      @(negedge clk);
      wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0;
      wbs_adr = 32'h3000_0804; wbs_sel = 4'hF;
      repeat (s) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_total++;
      if (csb0 !== {NB{1'b1}} || csb1 !== {NB{1'b1}} || wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0)
        $display("FAIL reset_mid_s%0d: csb0=%b csb1=%b ack=%b dat=%h, required all ones/0/0",
                 s, csb0, csb1, wbs_ack_o, wbs_dat_o);
      else n_pass++;
      rst = 1'b0; wbs_cyc = 1'b0; wbs_stb = 1'b0;
      acks = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (wbs_ack_o || rd_valid_o) acks++;
      end
      n_total++;
      if (acks != 0) $display("FAIL reset_mid_noack_s%0d: %0d acks, required 0", s, acks);
      else n_pass++;
    end
    wb_exp_q.push_back(32'hDEAD_BEEF);
    wb_txn(1'b0, 32'h3000_0804, 4'hF, 32'h0, rd, lat);
    exp = wb_exp_q.pop_front();
    n_total++;
    if (rd !== exp || lat !== 3)
      $display("FAIL reset_mid_recover: data=%h lat=%0d, required %h/3", rd, lat, exp);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_byte_mask();
    test_window_edges();
    test_cyc_abort();
    test_port1_burst();
    test_collision();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
